// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle N_BITS-wide subtractor computing a - b - borrow_in,
// CHUNK bits per cycle, least-significant chunk first, under a start/done handshake.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   i_start       request, accepted only when idle
//   i_a, i_b      minuend / subtrahend, latched on an accepted request
//   i_borrow_in   borrow-in, latched on an accepted request
//   o_busy        high while an operation is running or completing
//   o_done        one-cycle pulse when o_diff/o_borrow_out have just been updated
//   o_diff        last completed difference (modulo 2^N_BITS)
//   o_borrow_out  1 iff a < b + borrow_in (unsigned), held with o_diff
//   o_overflow    two's-complement overflow, held with o_diff
//                 (present only with SERIAL_SUB_OVERFLOW_EN defined)
//
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN
module serial_subtractor #(
  parameter int unsigned N_BITS = 64,
  parameter int unsigned CHUNK  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  input  logic              i_borrow_in,
  output logic              o_busy,
  output logic              o_done,
  output logic [N_BITS-1:0] o_diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic              o_overflow,
`endif
  output logic              o_borrow_out
);

  localparam int unsigned NumChunks = (CHUNK == 0) ? 1 : N_BITS / CHUNK;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  if ((CHUNK == 0) ? 1'b1 : ((N_BITS % CHUNK) != 0)) begin : g_param_check
    $error("serial_subtractor: CHUNK must be >= 1 and divide N_BITS");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] a_q, b_q;
  logic              borrow_q;
  logic [CntW-1:0]   cnt_q;
  logic [N_BITS-1:0] diff_q;
  logic              bout_q;

  logic              accept, advance, last_chunk, finish;
  logic [CHUNK:0]    sub_res;
  logic [N_BITS-1:0] diff_next;

  // Operands shift right each chunk, so the active chunk always sits in the low bits.
  assign sub_res    = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
                    - {{CHUNK{1'b0}}, borrow_q};
  assign last_chunk = (cnt_q == CntW'(NumChunks - 1));
  assign accept     = (state_q == StIdle) && i_start;
  assign advance    = (state_q == StRun);
  assign finish     = advance && last_chunk;

  if (NumChunks == 1) begin : g_single
    assign diff_next = sub_res[CHUNK-1:0];
  end else begin : g_multi
    // Holds the already-computed lower chunks; the newest chunk enters at the top.
    logic [N_BITS-CHUNK-1:0] acc_q;
    assign diff_next = {sub_res[CHUNK-1:0], acc_q};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (advance) begin
        acc_q <= diff_next[N_BITS-1:CHUNK];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StRun;
      StRun:   if (last_chunk) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      a_q      <= i_a;
      b_q      <= i_b;
      borrow_q <= i_borrow_in;
      cnt_q    <= '0;
    end else if (advance) begin
      a_q      <= a_q >> CHUNK;
      b_q      <= b_q >> CHUNK;
      borrow_q <= sub_res[CHUNK];
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // Visible results change only on completion, never showing partial chunks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (finish) begin
      diff_q <= diff_next;
      bout_q <= sub_res[CHUNK];
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits are shifted out of a_q/b_q, so keep them separately.
  logic a_msb_q, b_msb_q, ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= i_a[N_BITS-1];
        b_msb_q <= i_b[N_BITS-1];
      end
      if (finish) begin
        ovf_q <= (a_msb_q != b_msb_q) && (sub_res[CHUNK-1] != a_msb_q);
      end
    end
  end
  assign o_overflow = ovf_q;
`endif

  assign o_busy       = (state_q == StRun) || (state_q == StDone);
  assign o_done       = (state_q == StDone);
  assign o_diff       = diff_q;
  assign o_borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven and scoreboard-based self-checking bench for
// serial_subtractor with default parameters (N_BITS=64, CHUNK=8).
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [63:0] i_a, i_b;
  logic        i_borrow_in;
  logic        o_busy, o_done, o_borrow_out;
  logic [63:0] o_diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic        o_overflow;
`endif

  serial_subtractor #(.N_BITS(64), .CHUNK(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_borrow_in  (i_borrow_in),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_diff       (o_diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .o_overflow   (o_overflow),
`endif
    .o_borrow_out (o_borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] diff;
    logic        bout;
  } vec_t;

  typedef struct {
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Full-width reference: 65-bit subtract, bit 64 is the borrow.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bin);
    logic [64:0] r;
    exp_t e;
    r = {1'b0, a} - {1'b0, b} - {64'd0, bin};
    e.diff = r[63:0];
    e.bout = r[64];
    e.ovf  = (a[63] != b[63]) && (r[63] != a[63]);
    return e;
  endfunction

  // Scoreboard: every completion pops one expected result.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      exp_t e;
      chk("done_has_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("diff", o_diff, e.diff);
        chk("borrow_out", 64'(o_borrow_out), 64'(e.bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("overflow", 64'(o_overflow), 64'(e.ovf));
`endif
      end
    end
  end

  // Runs one operation; operands are scrambled after acceptance to catch resampling.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                       input exp_t e);
    int lat;
    @(negedge clk);
    i_start = 1'b1; i_a = a; i_b = b; i_borrow_in = bin;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_a = {$urandom, $urandom}; i_b = {$urandom, $urandom}; i_borrow_in = 1'($urandom);
    lat = 0;
    while (!o_done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd8);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(o_done), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    exp_t e;
    int   seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   seen;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 1'b0,
                64'hAAAA_AAAA_AAAA_AAAA, 1'b0};
    vecs[1] = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[5] = '{64'h5, 64'h2, 1'b0, 64'h3, 1'b0};
    vecs[6] = '{64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 1'b0,
                64'h0000_0000_0000_00FF, 1'b0};
    for (int i = 7; i < 10; i++) begin
      vecs[i].a   = {$urandom, $urandom};
      vecs[i].b   = {$urandom, $urandom};
      vecs[i].bin = 1'($urandom);
      e = model(vecs[i].a, vecs[i].b, vecs[i].bin);
      vecs[i].diff = e.diff;
      vecs[i].bout = e.bout;
    end

    rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    chk("reset_diff", o_diff, 64'd0);
    chk("reset_bout", 64'(o_borrow_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e = model(vecs[i].a, vecs[i].b, vecs[i].bin);
      e.diff = vecs[i].diff;
      e.bout = vecs[i].bout;
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, e);
    end

    // Start during RUN is ignored; busy covers k..k+8.
    @(negedge clk);
    i_start = 1'b1; i_a = 64'd10; i_b = 64'd3; i_borrow_in = 1'b0;
    sb_q.push_back(model(64'd10, 64'd3, 1'b0));
    @(posedge clk);
    #1;
    chk("busy_edge_k", 64'(o_busy), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) begin
        i_start = 1'b1; i_a = 64'd0; i_b = 64'd1;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("busy_edge_k%0d", i), 64'(o_busy), 64'd1);
      chk($sformatf("done_edge_k%0d", i), 64'(o_done), 64'(i == 8));
    end
    @(posedge clk);
    #1;
    chk("busy_after_done", 64'(o_busy), 64'd0);

    // Reset mid-operation aborts silently.
    @(negedge clk);
    i_start = 1'b1; i_a = 64'd100; i_b = 64'd1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_done", 64'(o_done), 64'd0);
    chk("abort_diff", o_diff, 64'd0);
    chk("abort_bout", 64'(o_borrow_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (o_done || o_busy) seen++;
    end
    chk("no_activity_after_abort", 64'(seen), 64'd0);
    do_op(64'd5, 64'd2, 1'b0, model(64'd5, 64'd2, 1'b0));

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
